// File: rtl/mfp_pmod_als_spi_responder.sv
// mfp_pmod_als_spi_responder
//
// SPI slave that stands in for a PmodALS light sensor (ADC081S021-style read-only SPI).
// System logic hands 16-bit words over a valid/ready handshake into a one-word shadow
// buffer. Each frame started by the master (cs falling) transmits the shadow word MSB
// first on sdo, one bit per sck falling edge. If the shadow is empty, the previous word
// is repeated and an underrun is flagged.
//
// Ports:
//   clock       - system clock
//   reset       - synchronous reset, active-high
//   cs          - SPI chip select from the master, active-low, asynchronous to clock
//   sck         - SPI clock from the master, asynchronous to clock
//   sdo         - registered serial data to the master
//   data_in     - word to transmit
//   data_valid  - data_in is valid
//   data_ready  - shadow buffer empty; the word is taken when valid and ready are both high
//   frame_done  - one-cycle pulse: cs rose after exactly WIDTH bits were presented
//   frame_error - one-cycle pulse: cs rose before WIDTH bits were presented
//   underrun    - one-cycle pulse: frame started with an empty shadow; last word repeated
module mfp_pmod_als_spi_responder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_SDO    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cs,
  input  logic             sck,
  output logic             sdo,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             frame_done,
  output logic             frame_error,
  output logic             underrun
);

  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam int unsigned WaitW = $clog2(SYNC_STAGES + 1);

  localparam logic [CntW-1:0]  BitsFull = CntW'(WIDTH);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(SYNC_STAGES);

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StArmed,
    StShift,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              sdo_q, sdo_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_error_q, frame_error_d;
  logic              underrun_q, underrun_d;

  logic accept;
  logic frame_end;

  assign accept    = data_valid & ~shadow_full_q;
  assign frame_end = cs_rise & ((state_q == StArmed) | (state_q == StShift) |
                                (state_q == StDone));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StWaitHigh;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // The sync chain resets to all ones, so a high value only counts once the chain
      // has been refilled from the pin; a cs held low through reset is never mistaken
      // for an idle bus.
      StWaitHigh: if ((wait_cnt_q == WaitMax) && cs_s) state_d = StIdle;
      StIdle:     if (cs_fall) state_d = StArmed;
      StArmed: begin
        if (cs_rise)       state_d = StIdle;
        else if (sck_fall) state_d = StShift;
      end
      StShift: begin
        if (cs_rise)                                state_d = StIdle;
        else if (sck_fall && bit_cnt_q == BitsFull) state_d = StDone;
      end
      StDone:     if (cs_rise) state_d = StIdle;
      default:    state_d = StWaitHigh;
    endcase
  end

  // Datapath / output next-state logic
  always_comb begin
    sdo_d         = IDLE_SDO;
    shift_d       = shift_q;
    last_d        = last_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = '0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    underrun_d    = 1'b0;

    if (frame_end) begin
      frame_done_d  = (bit_cnt_q == BitsFull);
      frame_error_d = (bit_cnt_q != BitsFull);
    end

    case (state_q)
      StWaitHigh: begin
        wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
      end
      StIdle: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          if (shadow_full_q) begin
            shift_d       = shadow_q;
            last_d        = shadow_q;
            shadow_full_d = 1'b0;
          end else begin
            shift_d    = last_q;
            underrun_d = 1'b1;
          end
        end
      end
      StArmed: begin
        if (!cs_rise && sck_fall) begin
          sdo_d     = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = CntW'(1);
        end
      end
      StShift: begin
        if (cs_rise) begin
          sdo_d = IDLE_SDO;
        end else if (sck_fall) begin
          // The fall after the last bit only returns sdo to idle.
          if (bit_cnt_q != BitsFull) begin
            sdo_d     = shift_q[WIDTH-1];
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else begin
          sdo_d = sdo_q;
        end
      end
      default: ;
    endcase

    // Only possible while the shadow is empty, so it never collides with a shadow load.
    if (accept) begin
      shadow_d      = data_in;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q       <= '0;
      last_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      sdo_q         <= IDLE_SDO;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      last_q        <= last_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      sdo_q         <= sdo_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sdo         = sdo_q;
  assign data_ready  = ~shadow_full_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign underrun    = underrun_q;

endmodule

// File: doc/mfp_pmod_als_spi_responder.md
Name: mfp_pmod_als_spi_responder

Overview:
SPI slave that emulates the PmodALS light sensor (ADC081S021-style read-only SPI). It drives serial data on sdo in response to the cs/sck master that samples the sensor. System logic loads 16-bit words through a valid/ready handshake into a one-word shadow buffer. The block serves as a loopback sensor stand-in on boards without the Pmod and as a synthesizable bench model.

Parameters:
WIDTH, 16, bits per frame, sent MSB first.
SYNC_STAGES, 2, synchronizer flops on cs and sck (≥2).
IDLE_SDO, 1'b0, sdo level when no bit is being presented.

Ports:
clock  input  1  system clock
reset  input  1  synchronous reset, active-high
cs  input  1  SPI chip select from master, active-low, asynchronous to clock
sck  input  1  SPI clock from master, asynchronous to clock
sdo  output  1  serial data to master, registered
data_in  input  WIDTH  word to transmit
data_valid  input  1  data_in valid
data_ready  output  1  shadow buffer empty; the word is accepted when data_valid and data_ready are both 1
frame_done  output  1  one-cycle pulse: cs rose after exactly WIDTH bits were presented
frame_error  output  1  one-cycle pulse: cs rose with fewer than WIDTH bits presented
underrun  output  1  one-cycle pulse: frame started with shadow empty, so the last word was repeated

Behaviour:
- Synchronizers: cs and sck each pass through SYNC_STAGES flops, then one "previous" flop. Sync and previous flops reset to 1. An edge is detected in the cycle where the synchronized value differs from the previous value.
- sdo latency: sdo changes on the clock edge after edge detect, i.e. SYNC_STAGES+1 clocks after the pin transition. The master must hold each sck phase ≥ SYNC_STAGES+2 clocks. A master with sck period 16 (8-clock phases) meets this.
- States:
  - WAIT_HIGH (reset state): sdo=IDLE_SDO. Go to IDLE when synced cs is 1. A cs held low through reset is ignored until it rises.
  - IDLE: sdo=IDLE_SDO. On cs falling edge: load the shift register and go to ARMED.
    - Shadow full: shift←shadow, last←shadow, shadow emptied.
    - Shadow empty: shift←last and underrun pulses.
  - ARMED: sdo=IDLE_SDO. On sck falling edge: sdo←shift[WIDTH-1], shift left, bit_cnt←1, go to SHIFT.
  - SHIFT: on each sck falling edge, present the next bit and increment bit_cnt. On the falling edge with bit_cnt==WIDTH, sdo←IDLE_SDO and go to DONE.
  - DONE: sdo=IDLE_SDO. Additional sck edges are ignored.
- Frame end: a cs rising edge in any of ARMED, SHIFT or DONE returns to IDLE and sets sdo=IDLE_SDO.
  - frame_done pulses if bit_cnt==WIDTH.
  - Otherwise frame_error pulses. An aborted word is not retransmitted; last still holds it.
- sck rising edges are ignored; the master samples on them. sck edges while cs is high are ignored.
- Handshake: data_ready = ~shadow_full. Acceptance sets shadow_full next cycle.
  - Accept and frame load in the same cycle with shadow previously empty: the frame uses last (underrun pulses) and the new word stays in shadow.
  - Accept and load in the same cycle with shadow full cannot occur, because data_ready=0.
- Reset values: sdo=IDLE_SDO, data_ready=1, frame_done=frame_error=underrun=0, shadow/shift/last=0, bit_cnt=0, state=WAIT_HIGH.
- Reset mid-frame: outputs return to reset values next clock. The remainder of the frame is ignored until cs is seen high.

Test Plan:
1. Load 16'hA5C3, then run a master frame (cs low 256 clocks, sck period 16, sample before each sck rise) -> master captures 16'hA5C3; frame_done pulses once; data_ready back to 1 after load.
2. No load after 16'h1234 frame, run second frame -> master captures 16'h1234 again; underrun pulses once at cs fall.
3. Raise cs after 5 sck falls while sending 16'hFFFF -> frame_error pulses, no frame_done; next frame with new word 16'h0001 is captured correctly.
4. data_valid held with 16'hBEEF and 16'hCAFE back-to-back -> only BEEF accepted (data_ready=0 second cycle); CAFE accepted only after the frame loads BEEF.
5. Assert reset at sck fall 8 of a frame, cs still low -> sdo=0 next cycle; sck edges ignored until cs rises; following frame transmits 16'h0000 with underrun.
6. cs low with 20 sck cycles, word 16'h8001 -> master's first 16 samples give 16'h8001; sdo=0 for extra bits; frame_done pulses at cs rise.
